// File: rtl/write_mem.sv
// Capture-side writer for the logic analyzer's circular sample memory.
// Writes samples at a wrapping pointer, qualifies the trigger, then freezes and publishes waddr.
module write_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] post_depth,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  trigger,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  capture_done
);

  localparam int unsigned MEMORY_SIZE = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FillMax = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

  typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   wptr_q;
  logic [ADDR_WIDTH:0]     fill_cnt_q;
  logic [ADDR_WIDTH-1:0]   post_cnt_q;
  logic [ADDR_WIDTH-1:0]   post_depth_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [ADDR_WIDTH-1:0]   trig_addr_q;
  logic                    capture_done_q;

  logic [ADDR_WIDTH-1:0]   pre_needed;
  logic                    trig_ok;

  // MEMORY_SIZE - 1 is all ones at ADDR_WIDTH bits.
  assign pre_needed = {ADDR_WIDTH{1'b1}} - post_depth_q;
  assign trig_ok    = sample_valid && trigger && (fill_cnt_q >= {1'b0, pre_needed});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      wptr_q         <= '0;
      fill_cnt_q     <= '0;
      post_cnt_q     <= '0;
      post_depth_q   <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      waddr_q        <= '0;
      trig_addr_q    <= '0;
      capture_done_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (abort) begin
        state_q        <= StIdle;
        capture_done_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (arm) begin
              state_q        <= StArmed;
              wptr_q         <= '0;
              fill_cnt_q     <= '0;
              post_depth_q   <= post_depth;
              trig_addr_q    <= '0;
              capture_done_q <= 1'b0;
            end else if (state_q == StDone) begin
              // Published one edge after the final write so readers never race it.
              capture_done_q <= 1'b1;
              waddr_q        <= wptr_q;
            end
          end
          StArmed: begin
            if (sample_valid) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wptr_q;
              mem_wdata_q <= sample_in;
              wptr_q      <= wptr_q + 1'b1;
              if (fill_cnt_q != FillMax) fill_cnt_q <= fill_cnt_q + 1'b1;
              if (trig_ok) begin
                trig_addr_q <= wptr_q;
                post_cnt_q  <= post_depth_q;
                state_q     <= (post_depth_q == '0) ? StDone : StPost;
              end
            end
          end
          StPost: begin
            if (sample_valid) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wptr_q;
              mem_wdata_q <= sample_in;
              wptr_q      <= wptr_q + 1'b1;
              post_cnt_q  <= post_cnt_q - 1'b1;
              if (post_cnt_q == 1) state_q <= StDone;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign waddr        = waddr_q;
  assign trig_addr    = trig_addr_q;
  assign capture_done = capture_done_q;
  assign busy         = (state_q == StArmed) || (state_q == StPost);

endmodule

// File: tb/tb_write_mem.sv
// Scoreboard bench for write_mem: the driver predicts writes from the sample stream,
// a negedge monitor pops and compares every mem_we.
module tb_write_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic       abort;
  logic [3:0] post_depth;
  logic       sample_valid;
  logic [7:0] sample_in;
  logic       trigger;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [3:0] waddr;
  logic [3:0] trig_addr;
  logic       busy;
  logic       capture_done;

  write_mem #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .post_depth   (post_depth),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .trigger      (trigger),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .busy         (busy),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   last_we_cyc = -10;
  logic done_prev = 1'b0;
  logic tb_trig [0:79];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    cyc_n++;
    if (mem_we === 1'b1) begin
      last_we_cyc = cyc_n;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d want=none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (capture_done === 1'b1 && done_prev !== 1'b1)
      check("done_one_cycle_after_last_we", cyc_n - last_we_cyc, 1);
    done_prev = capture_done;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_trig();
    for (int i = 0; i < 80; i++) tb_trig[i] = 1'b0;
  endtask

  task automatic do_arm(input int pd);
    sample_valid = 1'b0;
    trigger      = 1'b0;
    arm          = 1'b1;
    post_depth   = 4'(pd);
    cyc();
    arm        = 1'b0;
    post_depth = 4'($urandom);  // must have been latched already
    check("arm_done_clear", {31'd0, capture_done}, 0);
    check("arm_busy", {31'd0, busy}, 1);
    check("arm_trig_addr_clear", {28'd0, trig_addr}, 0);
  endtask

  task automatic run_capture(input int pd, input int gap_at, input bit rnd_gaps, input bit noise);
    int  pre, t, last, n;
    wr_t w;
    pre = 15 - pd;
    t   = -1;
    for (int i = 0; i < 80; i++) if (t < 0 && tb_trig[i] && i >= pre) t = i;
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL model_setup got=no_trigger want=trigger");
      return;
    end
    last = t + pd;
    for (int i = 0; i <= last; i++) begin
      w.addr = 4'(i % 16);
      w.data = 8'(i);
      exp_q.push_back(w);
    end
    do_arm(pd);
    for (int i = 0; i <= last + 3; i++) begin
      n = 0;
      if (i == gap_at) n = 3;
      else if (rnd_gaps && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        sample_valid = 1'b0;
        trigger      = 1'($urandom_range(0, 1));
        sample_in    = 8'($urandom);
        cyc();
      end
      sample_valid = 1'b1;
      sample_in    = 8'(i);
      trigger      = tb_trig[i];
      arm          = noise && (i <= last) && ($urandom_range(0, 3) == 0);
      cyc();
      arm = 1'b0;
    end
    sample_valid = 1'b0;
    trigger      = 1'b0;
    for (int k = 0; k < 5 && capture_done !== 1'b1; k++) cyc();
    check("capture_done", {31'd0, capture_done}, 1);
    check("trig_addr", {28'd0, trig_addr}, t % 16);
    check("waddr", {28'd0, waddr}, (last + 1) % 16);
    check("busy_after_done", {31'd0, busy}, 0);
    check("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    wr_t w;
    int  pre;
    reset = 1'b0; arm = 1'b0; abort = 1'b0; post_depth = '0;
    sample_valid = 1'b0; sample_in = '0; trigger = 1'b0;
    #1;
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", {28'd0, mem_addr}, 0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst_waddr", {28'd0, waddr}, 0);
    check("rst_trig_addr", {28'd0, trig_addr}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, capture_done}, 0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    check("idle_busy", {31'd0, busy}, 0);

    // Nominal: pulse on sample 20.
    clear_trig(); tb_trig[20] = 1'b1;
    run_capture(5, -1, 1'b0, 1'b0);
    // Early trigger held high from sample 3.
    clear_trig(); for (int i = 3; i < 80; i++) tb_trig[i] = 1'b1;
    run_capture(5, -1, 1'b0, 1'b0);
    // Zero post depth, trigger always high.
    clear_trig(); for (int i = 0; i < 80; i++) tb_trig[i] = 1'b1;
    run_capture(0, -1, 1'b0, 1'b0);
    // Three-cycle valid gap inside POST.
    clear_trig(); tb_trig[20] = 1'b1;
    run_capture(5, 22, 1'b0, 1'b0);
    // Re-arm from DONE with arm pulses during ARMED/POST.
    run_capture(5, -1, 1'b0, 1'b1);

    // Abort from DONE drops capture_done.
    abort = 1'b1; cyc(); abort = 1'b0;
    check("abort_done_clear", {31'd0, capture_done}, 0);
    check("abort_done_busy", {31'd0, busy}, 0);

    // Abort mid-ARMED, with a simultaneous sample and arm that must be dropped.
    do_arm(5);
    for (int i = 0; i < 5; i++) begin
      w.addr = 4'(i); w.data = 8'(i); exp_q.push_back(w);
    end
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; sample_in = 8'(i); trigger = 1'b1; cyc();
    end
    abort = 1'b1; arm = 1'b1; sample_in = 8'd5; cyc();
    abort = 1'b0; arm = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, capture_done}, 0);
    for (int i = 6; i < 9; i++) begin
      sample_in = 8'(i); cyc();
    end
    sample_valid = 1'b0; trigger = 1'b0;
    cyc();
    check("abort_pending", exp_q.size(), 0);

    // Randomized captures.
    for (int r = 0; r < 6; r++) begin
      int pd;
      pd  = $urandom_range(0, 15);
      pre = 15 - pd;
      clear_trig();
      for (int i = 0; i < 80; i++) tb_trig[i] = ($urandom_range(0, 7) == 0);
      tb_trig[pre + $urandom_range(0, 20)] = 1'b1;
      run_capture(pd, -1, 1'b1, 1'b1);
    end

    // Reset in the middle of POST.
    clear_trig(); tb_trig[20] = 1'b1;
    do_arm(5);
    for (int i = 0; i <= 22; i++) begin
      w.addr = 4'(i % 16); w.data = 8'(i); exp_q.push_back(w);
    end
    for (int i = 0; i <= 22; i++) begin
      sample_valid = 1'b1; sample_in = 8'(i); trigger = tb_trig[i]; cyc();
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_mem_we", {31'd0, mem_we}, 0);
    check("mid_rst_mem_addr", {28'd0, mem_addr}, 0);
    check("mid_rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("mid_rst_waddr", {28'd0, waddr}, 0);
    check("mid_rst_trig_addr", {28'd0, trig_addr}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, capture_done}, 0);
    check("mid_rst_pending", exp_q.size(), 0);
    repeat (2) cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; sample_in = 8'(i); cyc();
    end
    sample_valid = 1'b0; trigger = 1'b0;
    cyc();
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_done", {31'd0, capture_done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_mem.md
# write_mem

Capture-side writer for the internal logic analyzer's circular sample memory. While armed it writes every valid sample into the RAM at a wrapping write pointer, qualifies the trigger against a programmable pre-trigger depth, and writes a fixed number of post-trigger samples. It then stops and publishes `waddr`, the address of the oldest retained sample, which is the starting pointer the read side walks from.

## Interface
- `DATA_WIDTH`, default 8: sample width.
- `ADDR_WIDTH`, default 4: memory address width; `MEMORY_SIZE` = 2**`ADDR_WIDTH` (derived, not overridable).

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-low.
- `arm` input, 1 bit: start or restart a capture; honoured in IDLE and DONE only.
- `abort` input, 1 bit: synchronous return to IDLE from any state.
- `post_depth` input, `ADDR_WIDTH` bits: samples written after the trigger sample; latched when `arm` is accepted.
- `sample_valid` input, 1 bit: `sample_in` is valid this cycle.
- `sample_in` input, `DATA_WIDTH` bits: probe data.
- `trigger` input, 1 bit: trigger condition, sampled together with `sample_valid`.
- `mem_we` output, 1 bit: RAM write strobe.
- `mem_addr` output, `ADDR_WIDTH` bits: RAM write address.
- `mem_wdata` output, `DATA_WIDTH` bits: RAM write data.
- `waddr` output, `ADDR_WIDTH` bits: oldest-sample pointer, valid while `capture_done`=1.
- `trig_addr` output, `ADDR_WIDTH` bits: address holding the trigger sample.
- `busy` output, 1 bit: high in ARMED or POST.
- `capture_done` output, 1 bit: memory is frozen and readable.

## Operation
- States: IDLE, ARMED, POST, DONE. On reset: IDLE. All outputs are 0, including `wptr`, `fill_cnt` and `post_cnt`.
- `pre_needed` = `MEMORY_SIZE` − 1 − `post_depth_latched`. Range is 0..`MEMORY_SIZE`−1.
- IDLE or DONE, `arm`=1:
  - go to ARMED; `wptr`←0, `fill_cnt`←0; latch `post_depth`.
  - `capture_done` and `trig_addr` clear; `waddr` holds.
- ARMED, each cycle with `sample_valid`=1:
  - write `sample_in` at `wptr`; `wptr`←`wptr`+1, wrapping mod `MEMORY_SIZE`.
  - `fill_cnt`←`fill_cnt`+1, saturating at `MEMORY_SIZE`.
- ARMED, `sample_valid` & `trigger` & (`fill_cnt` ≥ `pre_needed`), where `fill_cnt` is the value before this sample:
  - the trigger sample is written normally; `trig_addr`←`wptr`.
  - `post_cnt`←`post_depth_latched`.
  - next state is DONE if `post_depth_latched`=0, else POST.
- A trigger that does not meet the qualifier is ignored with no side effects; a trigger held high fires on the first qualifying sample.
- POST, each valid sample:
  - write it; advance `wptr`; `post_cnt`←`post_cnt`−1.
  - on the sample where `post_cnt`=1, go to DONE.
  - `trigger` is ignored.
- DONE:
  - no writes; `waddr`=`wptr` (next write position, i.e. the oldest sample once the buffer has wrapped).
  - stays in DONE until `arm`, `abort` or reset.
- `arm` in ARMED or POST is ignored.
- `abort` has priority over `arm`: go to IDLE, cancel any pending write, clear `capture_done`.
- `sample_valid`=0 cycles: no write; all counters hold.
- All arithmetic is `ADDR_WIDTH` bits, wrap-around; `fill_cnt` is `ADDR_WIDTH`+1 bits.

## Timing
- Write port is registered: a sample accepted at edge N appears on `mem_we`/`mem_addr`/`mem_wdata` during cycle N..N+1, with `mem_we`=1 for exactly one cycle.
- The state moves to DONE at the same edge E as the final accepted sample. The last `mem_we` is high during E..E+1.
- `capture_done` and `waddr` update at edge E+1, so the read side never sees done before the last write lands.
- `busy` follows the state register, with no extra delay.
- Asynchronous reset deasserts all outputs immediately, independent of `clk`, including a `mem_we` in flight.
- Throughput: one sample per cycle, no back-pressure.

## Test plan
All cases use `ADDR_WIDTH`=4 (`MEMORY_SIZE`=16) and `sample_in` = sample index 0,1,2,…
- Nominal: `post_depth`=5, `sample_valid`=1 continuously, `trigger` pulse on sample 20.
  - 26 `mem_we` pulses; sample 20 at addr 4; samples 21..25 at addrs 5..9.
  - `trig_addr`=4, `waddr`=10; `capture_done` rises one cycle after the last `mem_we`.
- Early trigger: `post_depth`=5 (`pre_needed`=10), `trigger` high from sample 3 onward.
  - fires at sample 10: `trig_addr`=10; done after sample 15; `waddr`=0.
- Zero post depth: `post_depth`=0, `trigger` high from sample 0.
  - fires at sample 15: `trig_addr`=15; DONE with no POST state; `waddr`=0; exactly 16 writes.
- Valid gaps: nominal case with `sample_valid`=0 for 3 cycles inside POST.
  - no `mem_we` during the gap; `post_cnt` holds; final addresses identical to the nominal case.
- Reset/abort: assert `reset` low mid-POST.
  - all outputs 0 immediately; IDLE after release.
  - separately, `abort` mid-ARMED gives IDLE next edge, no further `mem_we`, `capture_done`=0.
- Re-arm: `arm` in DONE, then repeat the nominal case.
  - identical addresses; `capture_done` low from the edge after `arm`; `arm` pulses during ARMED/POST have no effect.
